// File: rtl/ascon_pack.sv
// Shared types for the ASCON stream driver: word types and the driver FSM state encoding.
package ascon_pack;

  localparam int unsigned BLOCK_WIDTH = 64;

  typedef logic [63:0]  u64_t;
  typedef logic [127:0] u128_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StWaitTag,
    StDone
  } driver_state_e;

endpackage

// File: rtl/ascon_stream_router.sv
// Combinational AD/PT phase select: steers the single input stream into the AD or PT FIFO.
module ascon_stream_router #(
  parameter int unsigned DataAddrWidth = 7
) (
  input  logic                     run_i,
  input  logic [DataAddrWidth-1:0] ad_cnt_i,
  input  logic [DataAddrWidth-1:0] ad_size_i,
  input  logic [DataAddrWidth-1:0] pt_cnt_i,
  input  logic [DataAddrWidth-1:0] pt_size_i,
  input  logic                     s_valid_i,
  input  logic                     ad_full_i,
  input  logic                     pt_full_i,
  output logic                     s_ready_o,
  output logic                     ad_push_o,
  output logic                     pt_push_o
);

  logic ad_phase;
  logic pt_phase;

  // AD strictly precedes PT; a word only ever lands in one FIFO.
  assign ad_phase  = run_i && (ad_cnt_i < ad_size_i);
  assign pt_phase  = run_i && !ad_phase && (pt_cnt_i < pt_size_i);

  assign s_ready_o = (ad_phase && !ad_full_i) || (pt_phase && !pt_full_i);
  assign ad_push_o = s_valid_i && s_ready_o && ad_phase;
  assign pt_push_o = s_valid_i && s_ready_o && pt_phase;

endmodule

// File: rtl/ascon_stream_driver.sv
// Host-side driver for the ASCON AEAD wrapper FIFO interface.
// Optional watchdog abort enabled by defining ASCON_STREAM_DRIVER_TIMEOUT_EN.
module ascon_stream_driver
  import ascon_pack::*;
#(
  parameter int unsigned DataAddrWidth = 7,
  parameter int unsigned BlockWidth    = BLOCK_WIDTH,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DataAddrWidth-1:0] ad_size_i,
  input  logic [DataAddrWidth-1:0] pt_size_i,
  input  logic                     go_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output u128_t                    tag_o,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [BlockWidth-1:0]    s_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [BlockWidth-1:0]    m_data_o,
  output logic                     start_o,
  input  logic                     ready_i,
  input  logic                     tag_valid_i,
  input  u128_t                    tag_i,
  output logic                     ad_push_o,
  output logic [BlockWidth-1:0]    ad_o,
  input  logic                     ad_full_i,
  output logic                     pt_push_o,
  output logic [BlockWidth-1:0]    pt_o,
  input  logic                     pt_full_i,
  output logic                     ct_pop_o,
  input  logic [BlockWidth-1:0]    ct_i,
  input  logic                     ct_empty_i
);

  driver_state_e state_q, state_d;
  logic [DataAddrWidth-1:0] ad_size_q, ad_size_d;
  logic [DataAddrWidth-1:0] pt_size_q, pt_size_d;
  logic [DataAddrWidth-1:0] ad_cnt_q, ad_cnt_d;
  logic [DataAddrWidth-1:0] pt_cnt_q, pt_cnt_d;
  logic [DataAddrWidth-1:0] ct_cnt_q, ct_cnt_d;
  u128_t tag_q, tag_d;
  logic  cap_q, cap_d;
  logic  start_q, start_d;

  logic in_run;
  logic in_active;
  logic cap_now;
  logic ad_push;
  logic pt_push;
  logic ct_pop;
  logic ct_valid;

  assign in_run    = (state_q == StRun);
  assign in_active = (state_q == StStart) || in_run || (state_q == StWaitTag);
  assign cap_now   = in_active && tag_valid_i && !cap_q;

  ascon_stream_router #(
    .DataAddrWidth(DataAddrWidth)
  ) u_router (
    .run_i     (in_run),
    .ad_cnt_i  (ad_cnt_q),
    .ad_size_i (ad_size_q),
    .pt_cnt_i  (pt_cnt_q),
    .pt_size_i (pt_size_q),
    .s_valid_i (s_valid_i),
    .ad_full_i (ad_full_i),
    .pt_full_i (pt_full_i),
    .s_ready_o (s_ready_o),
    .ad_push_o (ad_push),
    .pt_push_o (pt_push)
  );

  // CT drain runs alongside the feed; it stops once pt_size words have left.
  assign ct_valid  = in_run && !ct_empty_i && (ct_cnt_q < pt_size_q);
  assign ct_pop    = ct_valid && m_ready_i;

  assign ad_push_o = ad_push;
  assign pt_push_o = pt_push;
  assign ad_o      = s_data_i;
  assign pt_o      = s_data_i;
  assign m_valid_o = ct_valid;
  assign m_data_o  = ct_i;
  assign ct_pop_o  = ct_pop;
  assign start_o   = start_q;
  assign busy_o    = in_active;
  assign done_o    = (state_q == StDone);
  assign tag_o     = tag_q;

`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        activity;

  assign activity = ad_push || pt_push || ct_pop || cap_now;
  assign err_o    = err_q;
`else
  assign err_o    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ad_size_d = ad_size_q;
    pt_size_d = pt_size_q;
    ad_cnt_d  = ad_cnt_q;
    pt_cnt_d  = pt_cnt_q;
    ct_cnt_d  = ct_cnt_q;
    tag_d     = tag_q;
    cap_d     = cap_q;
    start_d   = 1'b0;
`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          ad_size_d = ad_size_i;
          pt_size_d = pt_size_i;
          ad_cnt_d  = '0;
          pt_cnt_d  = '0;
          ct_cnt_d  = '0;
          cap_d     = 1'b0;
`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
          err_d     = 1'b0;
          wd_d      = '0;
`endif
          state_d   = StStart;
        end
      end
      StStart: begin
        if (ready_i) begin
          start_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (ad_push) ad_cnt_d = ad_cnt_q + 1'b1;
        if (pt_push) pt_cnt_d = pt_cnt_q + 1'b1;
        if (ct_pop)  ct_cnt_d = ct_cnt_q + 1'b1;
        if ((ad_cnt_q == ad_size_q) && (pt_cnt_q == pt_size_q) && (ct_cnt_q == pt_size_q)) begin
          state_d = StWaitTag;
        end
      end
      StWaitTag: begin
        if (cap_q || cap_now) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The wrapper may raise tag_valid before the last CT word drains.
    if (cap_now) begin
      tag_d = tag_i;
      cap_d = 1'b1;
    end

`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
    if (in_active) begin
      if (activity) begin
        wd_d = '0;
      end else if (wd_q + 32'd1 >= TimeoutCycles) begin
        wd_d    = '0;
        err_d   = 1'b1;
        start_d = 1'b0;
        state_d = StIdle;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ad_size_q <= '0;
      pt_size_q <= '0;
      ad_cnt_q  <= '0;
      pt_cnt_q  <= '0;
      ct_cnt_q  <= '0;
      tag_q     <= '0;
      cap_q     <= 1'b0;
      start_q   <= 1'b0;
`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ad_size_q <= ad_size_d;
      pt_size_q <= pt_size_d;
      ad_cnt_q  <= ad_cnt_d;
      pt_cnt_q  <= pt_cnt_d;
      ct_cnt_q  <= ct_cnt_d;
      tag_q     <= tag_d;
      cap_q     <= cap_d;
      start_q   <= start_d;
`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ascon_stream_driver.sv
// Scoreboard bench for ascon_stream_driver with a behavioural wrapper/FIFO model.
module tb_ascon_stream_driver;
  import ascon_pack::*;

  localparam int unsigned AW    = 7;
  localparam u64_t        CtKey = 64'hA5A5_5A5A_0F0F_F0F0;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ad_size_i, pt_size_i;
  logic          go_i, busy_o, done_o, err_o;
  u128_t         tag_o;
  logic          s_valid_i, s_ready_o;
  u64_t          s_data_i;
  logic          m_valid_o, m_ready_i;
  u64_t          m_data_o;
  logic          start_o, ready_i, tag_valid_i;
  u128_t         tag_i;
  logic          ad_push_o, ad_full_i, pt_push_o, pt_full_i, ct_pop_o, ct_empty_i;
  u64_t          ad_o, pt_o, ct_i;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_done   = 0;
  int    n_start  = 0;
  u64_t  exp_ad[$];
  u64_t  exp_pt[$];
  u64_t  exp_ct[$];
  u128_t exp_tag[$];
  u64_t  ct_fifo[$];
  int    w_ad_sz = 0;
  int    w_pt_sz = 0;
  u128_t w_tag   = '0;
  bit    ct_stall  = 0;
  bit    rnd_ready = 0;

  ascon_stream_driver #(
    .DataAddrWidth(AW),
    .BlockWidth   (64),
    .TimeoutCycles(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ad_size_i  (ad_size_i),
    .pt_size_i  (pt_size_i),
    .go_i       (go_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .tag_o      (tag_o),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .start_o    (start_o),
    .ready_i    (ready_i),
    .tag_valid_i(tag_valid_i),
    .tag_i      (tag_i),
    .ad_push_o  (ad_push_o),
    .ad_o       (ad_o),
    .ad_full_i  (ad_full_i),
    .pt_push_o  (pt_push_o),
    .pt_o       (pt_o),
    .pt_full_i  (pt_full_i),
    .ct_pop_o   (ct_pop_o),
    .ct_i       (ct_i),
    .ct_empty_i (ct_empty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every DUT handshake is checked against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (ad_push_o) begin
        if (exp_ad.size() == 0) chk("ad_unexpected", ad_o, 128'hx);
        else chk("ad_word", ad_o, exp_ad.pop_front());
      end
      if (pt_push_o) begin
        if (exp_pt.size() == 0) chk("pt_unexpected", pt_o, 128'hx);
        else chk("pt_word", pt_o, exp_pt.pop_front());
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_ct.size() == 0) chk("ct_unexpected", m_data_o, 128'hx);
        else chk("ct_word", m_data_o, exp_ct.pop_front());
      end
      if (ct_pop_o && ct_empty_i) chk("pop_on_empty", ct_pop_o, 0);
      if (start_o) n_start++;
      if (done_o) begin
        n_done++;
        if (exp_tag.size() == 0) chk("done_unexpected", done_o, 0);
        else chk("tag", tag_o, exp_tag.pop_front());
      end
    end
  end

  // Wrapper model: CT = PT ^ CtKey, tag once all words are in and CT is drained.
  initial begin
    bit s_rst, d_pop, d_pt, d_ad, d_start, started;
    u64_t d_w;
    int got_ad, got_pt;
    started = 0; got_ad = 0; got_pt = 0;
    ready_i = 1'b1; tag_valid_i = 1'b0; tag_i = '0; ct_empty_i = 1'b1; ct_i = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; d_pop = ct_pop_o; d_pt = pt_push_o; d_w = pt_o;
      d_ad = ad_push_o; d_start = start_o;
      @(posedge clk); #1;
      tag_valid_i = 1'b0;
      if (s_rst) begin
        ct_fifo.delete(); started = 0; got_ad = 0; got_pt = 0;
      end else begin
        if (d_start) begin started = 1; got_ad = 0; got_pt = 0; end
        if (d_pop && ct_fifo.size() > 0) void'(ct_fifo.pop_front());
        if (d_ad) got_ad++;
        if (d_pt) begin got_pt++; ct_fifo.push_back(d_w ^ CtKey); end
        if (started && got_ad == w_ad_sz && got_pt == w_pt_sz && ct_fifo.size() == 0) begin
          tag_valid_i = 1'b1; tag_i = w_tag; started = 0;
        end
      end
      ct_empty_i = ct_stall || (ct_fifo.size() == 0);
      if (ct_fifo.size() > 0) ct_i = ct_fifo[0];
      else ct_i = '0;
    end
  end

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready_i = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic start_run(input int ad, input int pt, input u128_t tag);
    w_ad_sz = ad; w_pt_sz = pt; w_tag = tag;
    exp_tag.push_back(tag);
    ad_size_i = AW'(ad); pt_size_i = AW'(pt);
    go_i = 1'b1;
    @(posedge clk); #1;
    go_i = 1'b0;
  endtask

  task automatic send_word(input u64_t w, input bit is_ad);
    bit ok = 0;
    if (is_ad) exp_ad.push_back(w);
    else begin exp_pt.push_back(w); exp_ct.push_back(w ^ CtKey); end
    s_valid_i = 1'b1; s_data_i = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready_o) ok = 1;
      @(posedge clk); #1;
      if (ok) break;
    end
    s_valid_i = 1'b0;
    if (!ok) chk("stream_accept_timeout", ok, 1);
  endtask

  task automatic wait_done(input int bound);
    int d0 = n_done;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (n_done > d0) break;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", n_done - d0, 1);
  endtask

  task automatic chk_empty_queues();
    chk("ad_left", exp_ad.size(), 0);
    chk("pt_left", exp_pt.size(), 0);
    chk("ct_left", exp_ct.size(), 0);
  endtask

  initial begin
    int s0, d0, cnt;
    rst = 1'b1; go_i = 1'b0; ad_size_i = '0; pt_size_i = '0;
    s_valid_i = 1'b0; s_data_i = '0; ad_full_i = 1'b0; pt_full_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy_o, done_o, err_o, s_ready_o, m_valid_o, start_o,
                          ad_push_o, pt_push_o, ct_pop_o}, 0);
    chk("reset_tag", tag_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic run: 2 AD, 3 PT.
    s0 = n_start;
    start_run(2, 3, 128'h0123456789ABCDEF_0123456789ABCDEF);
    send_word(64'h1111_0000_0000_0001, 1);
    send_word(64'h1111_0000_0000_0002, 1);
    send_word(64'h2222_0000_0000_0001, 0);
    send_word(64'h2222_0000_0000_0002, 0);
    send_word(64'h2222_0000_0000_0003, 0);
    wait_done(100);
    chk("start_pulses_basic", n_start - s0, 1);
    chk("tag_hold", tag_o, 128'h0123456789ABCDEF_0123456789ABCDEF);
    chk("busy_after_done", busy_o, 0);
    chk_empty_queues();

    // AD FIFO full backpressure.
    start_run(2, 1, 128'hBBBB_0000_0000_0000_0000_0000_0000_BBBB);
    ad_full_i = 1'b1; s_valid_i = 1'b1; s_data_i = 64'h3333_0000_0000_0001;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("full_no_ready", {s_ready_o, ad_push_o}, 0);
      @(posedge clk); #1;
    end
    chk("busy_while_full", busy_o, 1);
    ad_full_i = 1'b0;
    send_word(64'h3333_0000_0000_0001, 1);
    send_word(64'h3333_0000_0000_0002, 1);
    send_word(64'h4444_0000_0000_0001, 0);
    wait_done(100);
    chk_empty_queues();

    // Zero sizes.
    s0 = n_start;
    start_run(0, 0, 128'hCCCC_1234_0000_0000_0000_0000_5678_CCCC);
    wait_done(50);
    chk("start_pulses_zero", n_start - s0, 1);
    chk("tag_zero_run", tag_o, 128'hCCCC_1234_0000_0000_0000_0000_5678_CCCC);

    // Random CT back-pressure.
    rnd_ready = 1;
    start_run(1, 4, 128'hDDDD_0000_0000_0000_0000_0000_0000_DDDD);
    send_word(64'h5555_0000_0000_0001, 1);
    for (int i = 0; i < 4; i++) send_word(64'h6666_0000_0000_0000 + 64'(i), 0);
    wait_done(400);
    rnd_ready = 0;
    chk_empty_queues();

    // Reset mid-RUN.
    start_run(2, 2, 128'hEEEE_0000_0000_0000_0000_0000_0000_EEEE);
    send_word(64'h7777_0000_0000_0001, 1);
    send_word(64'h7777_0000_0000_0002, 1);
    d0 = n_done;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrun_reset_outputs", {busy_o, done_o, err_o, s_ready_o, m_valid_o, start_o,
                                 ad_push_o, pt_push_o, ct_pop_o}, 0);
    chk("midrun_reset_tag", tag_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ad.delete(); exp_pt.delete(); exp_ct.delete(); exp_tag.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_reset", n_done - d0, 0);
    start_run(1, 1, 128'hF0F0_0000_0000_0000_0000_0000_0000_0F0F);
    send_word(64'h8888_0000_0000_0001, 1);
    send_word(64'h9999_0000_0000_0001, 0);
    wait_done(100);
    chk_empty_queues();

`ifdef ASCON_STREAM_DRIVER_TIMEOUT_EN
    // Watchdog: CT never appears, abort after 20 idle cycles.
    ct_stall = 1;
    d0 = n_done;
    start_run(0, 1, 128'h1357_0000_0000_0000_0000_0000_0000_2468);
    send_word(64'hAAAA_0000_0000_0001, 0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (err_o) break;
    end
    chk("timeout_err", err_o, 1);
    chk("timeout_cycles", cnt, 20);
    chk("timeout_idle", busy_o, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout_no_done", n_done - d0, 0);
    chk("timeout_err_sticky", err_o, 1);
    exp_ct.delete(); exp_tag.delete();
    ct_stall = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
